round_ctrl: RTL and testbench

//  Game round controller, directly downstream of the 0..9 time counter (Counter_time).

---
 rtl/round_ctrl_pkg.sv | 16 +
 rtl/round_ctrl_score_acc.sv | 42 ++++
 rtl/round_ctrl.sv | 110 +++++++++++
 tb/tb_round_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/round_ctrl_pkg.sv
// Shared definitions for the game round controller: FSM state encoding and default widths.
package round_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int unsigned T_MAX_DEF   = 9;
    localparam int unsigned TEMPO_W_DEF = 4;
    localparam int unsigned ROUND_W     = 4;

endpackage

// File: rtl/round_ctrl_score_acc.sv
// score_acc: saturating score adder. With ROUND_CTRL_TIME_BONUS_EN defined a correct
// answer is worth (T_MAX - tempo) + 1 points, otherwise exactly one point.
module score_acc
    import round_ctrl_pkg::*;
#(
    parameter int unsigned TEMPO_W = TEMPO_W_DEF,
    parameter int unsigned T_MAX   = T_MAX_DEF,
    parameter int unsigned SCORE_W = 8
) (
    input  logic [SCORE_W-1:0] score,
    input  logic [TEMPO_W-1:0] tempo,
    output logic [SCORE_W-1:0] sum
);

    localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

    logic [31:0] inc;
    logic [31:0] total;

`ifdef ROUND_CTRL_TIME_BONUS_EN
    // A tempo beyond T_MAX cannot come from the counter; treat it as the slowest answer.
    always_comb begin
        inc = 32'd1;
        if (32'(tempo) <= T_MAX) begin
            inc = T_MAX - 32'(tempo) + 32'd1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{tempo, 32'(T_MAX)};
    assign inc        = 32'd1;
`endif

    always_comb begin
        total = 32'(score) + inc;
        sum   = '1;
        if (total <= SCORE_MAX) begin
            sum = total[SCORE_W-1:0];
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// round_ctrl: game round sequencer driving the time counter's clear/enable and keeping score.
// Optional time bonus scoring via ROUND_CTRL_TIME_BONUS_EN (see score_acc).
module round_ctrl
    import round_ctrl_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = 8,
    parameter int unsigned TEMPO_W    = TEMPO_W_DEF,
    parameter int unsigned T_MAX      = T_MAX_DEF,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic               clkt,
    input  logic               R,
    input  logic               tick,
    input  logic               start,
    input  logic               enter,
    input  logic               hit,
    input  logic               end_time,
    input  logic [TEMPO_W-1:0] tempo,
    output logic               R_time,
    output logic               E_time,
    output logic [3:0]         round,
    output logic [SCORE_W-1:0] score,
    output logic               end_game,
    output logic               win
);

    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(MAX_ROUNDS);

    state_t               state;
    state_t               next_state;
    logic                 hit_q;
    logic [TEMPO_W-1:0]   tempo_q;
    logic [SCORE_W-1:0]   score_sum;

    score_acc #(
        .TEMPO_W (TEMPO_W),
        .T_MAX   (T_MAX),
        .SCORE_W (SCORE_W)
    ) u_score_acc (
        .score (score),
        .tempo (tempo_q),
        .sum   (score_sum)
    );

    assign E_time = (state == PLAY) && tick;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = SETUP;
            SETUP:   next_state = PLAY;
            PLAY: begin
                if (end_time)   next_state = DONE;
                else if (enter) next_state = CHECK;
            end
            CHECK: begin
                if (!hit_q || round == LAST_ROUND) next_state = DONE;
                else                               next_state = SETUP;
            end
            DONE:    if (start) next_state = SETUP;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clkt) begin
        if (!R) begin
            state    <= IDLE;
            R_time   <= 1'b1;
            round    <= '0;
            score    <= '0;
            end_game <= 1'b0;
            win      <= 1'b0;
            hit_q    <= 1'b0;
            tempo_q  <= '0;
        end else begin
            state    <= next_state;
            R_time   <= (next_state == IDLE) || (next_state == SETUP) || (next_state == DONE);
            end_game <= (next_state == DONE);
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        round <= '0;
                        score <= '0;
                        win   <= 1'b0;
                    end
                end
                SETUP: round <= round + 4'd1;
                PLAY: begin
                    if (end_time) begin
                        win <= 1'b0;
                    end else if (enter) begin
                        hit_q   <= hit;
                        tempo_q <= tempo;
                    end
                end
                CHECK: begin
                    if (hit_q) begin
                        score <= score_sum;
                        win   <= (round == LAST_ROUND);
                    end else begin
                        win   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Self-checking bench for round_ctrl with a behavioural 0..T_MAX time counter in the loop.
module tb_round_ctrl;

    localparam int MAX_ROUNDS = 9;
    localparam int TEMPO_W    = 4;
    localparam int T_MAX      = 9;
    localparam int SCORE_W    = 3;
    localparam int SMAX       = (1 << SCORE_W) - 1;

    logic               clkt = 1'b0;
    logic               R = 1'b0, tick = 1'b0, start = 1'b0, enter = 1'b0, hit = 1'b0;
    logic               end_time = 1'b0;
    logic [TEMPO_W-1:0] tempo = '0;
    logic               R_time, E_time, end_game, win;
    logic [3:0]         round;
    logic [SCORE_W-1:0] score;

    int n_cmp = 0;
    int n_err = 0;
    int cnt   = 0;
    bit cend  = 0;

    round_ctrl #(
        .MAX_ROUNDS (MAX_ROUNDS),
        .TEMPO_W    (TEMPO_W),
        .T_MAX      (T_MAX),
        .SCORE_W    (SCORE_W)
    ) dut (
        .clkt     (clkt),
        .R        (R),
        .tick     (tick),
        .start    (start),
        .enter    (enter),
        .hit      (hit),
        .end_time (end_time),
        .tempo    (tempo),
        .R_time   (R_time),
        .E_time   (E_time),
        .round    (round),
        .score    (score),
        .end_game (end_game),
        .win      (win)
    );

    always #5 clkt = ~clkt;

    function automatic int points(input int t);
`ifdef ROUND_CTRL_TIME_BONUS_EN
        return T_MAX - t + 1;
`else
        return 1;
`endif
    endfunction

    function automatic int sat_add(input int s, input int t);
        int v;
        v = s + points(t);
        return (v > SMAX) ? SMAX : v;
    endfunction

    // One clock: the counter model reacts to R_time/E_time seen before the edge; pulses drop after it.
    task automatic step();
        bit rt, et;
        #1;
        rt = R_time;
        et = E_time;
        @(posedge clkt);
        #1;
        if (rt) begin
            cnt = 0; cend = 0;
        end else if (et) begin
            if (cnt == T_MAX) cend = 1;
            else cnt++;
        end
        tempo = TEMPO_W'(cnt);
        end_time = cend;
        start = 0; enter = 0; hit = 0; tick = 0;
    endtask

    task automatic do_reset();
        R = 0; step(); step(); R = 1;
    endtask

    task automatic begin_game();
        start = 1; step(); step();
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap)) step();
            tick = 1; step();
        end
    endtask

    task automatic test_reset();
        R = 0; tick = 1; start = 1; step(); step();
        tick = 1; #1;
        n_cmp++; if (E_time !== 1'b0) begin n_err++; $display("FAIL rst_E_time: got %b expected 0", E_time); end
        n_cmp++; if (R_time !== 1'b1) begin n_err++; $display("FAIL rst_R_time: got %b expected 1", R_time); end
        n_cmp++; if (round !== 4'd0) begin n_err++; $display("FAIL rst_round: got %0d expected 0", round); end
        n_cmp++; if (score !== '0) begin n_err++; $display("FAIL rst_score: got %0d expected 0", score); end
        n_cmp++; if ({end_game, win} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b expected 00", {end_game, win}); end
        tick = 0; R = 1;
    endtask

    task automatic test_full_win();
        int s = 0;
        int t;
        do_reset();
        begin_game();
        for (int r = 1; r <= MAX_ROUNDS; r++) begin
            t = (r == 1) ? 3 : (r == 2) ? 5 : $urandom_range(0, 9);
            n_cmp++; if (round !== 4'(r)) begin n_err++; $display("FAIL win_round: got %0d expected %0d", round, r); end
            ticks(t, 1);
            if (r == 1) begin
                tick = 1; #1;
                n_cmp++; if (E_time !== 1'b1 || R_time !== 1'b0) begin n_err++; $display("FAIL play_E_R: got %b%b expected 10", E_time, R_time); end
                tick = 0;
            end
            enter = 1; hit = 1; step(); step();
            s = sat_add(s, t);
            if (r < MAX_ROUNDS) begin
                enter = 1; hit = 0; step();
            end
        end
        n_cmp++; if ({end_game, win} !== 2'b11) begin n_err++; $display("FAIL win_flags: got %b expected 11", {end_game, win}); end
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL win_score: got %0d expected %0d", score, s); end
        n_cmp++; if (round !== 4'(MAX_ROUNDS)) begin n_err++; $display("FAIL win_last_round: got %0d expected %0d", round, MAX_ROUNDS); end
    endtask

    task automatic test_timeout();
        do_reset();
        begin_game();
        ticks(10, 0);
        step();
        n_cmp++; if ({end_game, win} !== 2'b10) begin n_err++; $display("FAIL to_flags: got %b expected 10", {end_game, win}); end
        n_cmp++; if (score !== '0 || round !== 4'd1) begin n_err++; $display("FAIL to_score_round: got %0d/%0d expected 0/1", score, round); end
        n_cmp++; if (R_time !== 1'b1) begin n_err++; $display("FAIL to_R_time: got %b expected 1", R_time); end
    endtask

    task automatic test_wrong_answer();
        int s;
        do_reset();
        begin_game();
        enter = 1; hit = 1; step(); step(); enter = 1; step();
        s = sat_add(0, 0);
        ticks(2, 1);
        start = 1; step();
        n_cmp++; if (round !== 4'd2) begin n_err++; $display("FAIL start_in_play: got round %0d expected 2", round); end
        enter = 1; hit = 0; step();
        n_cmp++; if (end_game !== 1'b0) begin n_err++; $display("FAIL wrong_check: got end_game %b expected 0", end_game); end
        step();
        n_cmp++; if ({end_game, win} !== 2'b10) begin n_err++; $display("FAIL wrong_done: got %b expected 10", {end_game, win}); end
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL wrong_score: got %0d expected %0d", score, s); end
        start = 1; step(); step();
        n_cmp++; if (round !== 4'd1 || score !== '0) begin n_err++; $display("FAIL restart: got %0d/%0d expected 1/0", round, score); end
        n_cmp++; if (end_game !== 1'b0) begin n_err++; $display("FAIL restart_end: got %b expected 0", end_game); end
    endtask

    task automatic test_collision();
        int s;
        do_reset();
        begin_game();
        ticks(4, 0);
        enter = 1; hit = 1; step(); step(); step();
        s = sat_add(0, 4);
        ticks(10, 1);
        enter = 1; hit = 1; step();
        n_cmp++; if ({end_game, win} !== 2'b10) begin n_err++; $display("FAIL coll_flags: got %b expected 10", {end_game, win}); end
        step();
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL coll_score: got %0d expected %0d", score, s); end
        n_cmp++; if (round !== 4'd2) begin n_err++; $display("FAIL coll_round: got %0d expected 2", round); end
    endtask

    task automatic test_bonus_points();
        int s;
        do_reset();
        begin_game();
        enter = 1; hit = 1; step(); step();
        s = sat_add(0, 0);
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL pts_t0: got %0d expected %0d", score, s); end
        step();
        ticks(9, 0);
        enter = 1; hit = 1; step(); step();
        s = sat_add(s, 9);
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL pts_t9: got %0d expected %0d", score, s); end
    endtask

    task automatic test_reset_midgame();
        int s;
        do_reset();
        begin_game();
        ticks(6, 1);
        R = 0; tick = 1; step();
        n_cmp++; if (R_time !== 1'b1 || round !== 4'd0) begin n_err++; $display("FAIL mid_rst: got R_time %b round %0d expected 1/0", R_time, round); end
        n_cmp++; if (score !== '0 || end_game !== 1'b0) begin n_err++; $display("FAIL mid_rst_score: got %0d/%b expected 0/0", score, end_game); end
        R = 1; enter = 1; hit = 1; step();
        n_cmp++; if (round !== 4'd0 || R_time !== 1'b1) begin n_err++; $display("FAIL idle_enter: got round %0d R_time %b expected 0/1", round, R_time); end
        start = 1; enter = 1; hit = 1; step();
        enter = 1; hit = 1; step();
        n_cmp++; if (round !== 4'd1 || score !== '0) begin n_err++; $display("FAIL mid_restart: got %0d/%0d expected 1/0", round, score); end
        enter = 1; hit = 1; step(); step();
        s = sat_add(0, 0);
        n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL mid_cleared_tempo: got %0d expected %0d", score, s); end
    endtask

    task automatic test_random_games();
        int s, n, last;
        bit h, lost, won;
        for (int g = 0; g < 8; g++) begin
            do_reset();
            begin_game();
            s = 0; lost = 0; won = 0; last = 0;
            for (int r = 1; r <= MAX_ROUNDS && !lost && !won; r++) begin
                last = r;
                n_cmp++; if (round !== 4'(r)) begin n_err++; $display("FAIL rnd_round: got %0d expected %0d", round, r); end
                n = ($urandom_range(0, 9) == 0) ? 10 : $urandom_range(0, 9);
                ticks(n, 2);
                if (n >= 10) begin
                    enter = 1'($urandom_range(0, 1)); hit = 1; step();
                    lost = 1;
                end else begin
                    h = ($urandom_range(0, 4) != 0);
                    enter = 1; hit = h; start = 1'($urandom_range(0, 1)); step();
                    enter = 1'($urandom_range(0, 1)); hit = 1; step();
                    if (!h) lost = 1;
                    else begin
                        s = sat_add(s, n);
                        if (r == MAX_ROUNDS) won = 1;
                        else begin enter = 1'($urandom_range(0, 1)); hit = 1; step(); end
                    end
                end
            end
            n_cmp++; if ({end_game, win} !== {1'b1, won}) begin n_err++; $display("FAIL rnd_flags: game %0d got %b expected 1%b", g, {end_game, win}, won); end
            n_cmp++; if (score !== SCORE_W'(s)) begin n_err++; $display("FAIL rnd_score: game %0d got %0d expected %0d", g, score, s); end
            n_cmp++; if (round !== 4'(last)) begin n_err++; $display("FAIL rnd_end_round: game %0d got %0d expected %0d", g, round, last); end
        end
    endtask

    initial begin
        test_reset();
        test_full_win();
        test_timeout();
        test_wrong_answer();
        test_collision();
        test_bonus_points();
        test_reset_midgame();
        test_random_games();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
